// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo_if : receiver-side and consumer-side signals of the RX FIFO  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]         in_data;
    logic                     in_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     overflow_clr;

    modport master (
        output in_data, in_valid, out_ready, overflow_clr,
        input  out_data, out_valid, count, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready, overflow_clr,
        output out_data, out_valid, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo : edge-triggered byte capture into a show-ahead circular FIFO|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    uart_rx_fifo_if.slave   bus
);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = c_AW + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_in_valid_q;

    logic w_push_req;
    logic w_pop;
    logic w_full;
    logic w_push_ok;
    logic w_push_rej;

    assign w_push_req = bus.in_valid & ~r_in_valid_q;
    assign w_pop      = (r_count != '0) & bus.out_ready;
    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_push_rej = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // History resets to 1 so a level already high at release is not a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_in_valid_q <= 1'b1;
        end else begin
            r_in_valid_q <= bus.in_valid;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_rej) begin
                r_overflow <= 1'b1;
            end else if (bus.overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_valid = (r_count != '0);
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_fifo : directed self-checking bench for uart_rx_fifo           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        int tx_next;
        int rx_next;
        int cyc;
        int max_count;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_data      = '0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.overflow_clr = 1'b0;
        repeat (3) tick();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-traffic with 5 bytes stored
        for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i));
        check("pre_rst_count", 32'(bus.count), 32'd5);
        check("pre_rst_head", 32'(bus.out_data), 32'h60);
        #3;
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        #1;
        check("async_rst_count", 32'(bus.count), 32'd0);
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("held_valid_no_push", 32'(bus.count), 32'd0);
        bus.in_valid = 1'b0;
        tick();

        // Single byte, level held 30 cycles
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        check("single_count", 32'(bus.count), 32'd1);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_data", 32'(bus.out_data), 32'hA5);
        repeat (29) tick();
        check("single_held_count", 32'(bus.count), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("single_pop_count", 32'(bus.count), 32'd0);
        check("single_pop_valid", 32'(bus.out_valid), 32'd0);

        // Fill and overflow
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        check("full_count", 32'(bus.count), 32'd16);
        check("full_ovf", 32'(bus.overflow), 32'd0);
        push_byte(8'hFF);
        check("ovf_count", 32'(bus.count), 32'd16);
        check("ovf_set", 32'(bus.overflow), 32'd1);

        // Clear coincident with a rejected push: set wins
        bus.in_data      = 8'hEE;
        bus.in_valid     = 1'b1;
        bus.overflow_clr = 1'b1;
        tick();
        check("clr_vs_set", 32'(bus.overflow), 32'd1);
        check("clr_vs_set_count", 32'(bus.count), 32'd16);
        bus.in_valid = 1'b0;
        tick();
        bus.overflow_clr = 1'b0;
        check("clr_alone", 32'(bus.overflow), 32'd0);

        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain1_%0d", i), 32'(bus.out_data), 32'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        check("drain1_empty", 32'(bus.out_valid), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h20 + i));
        check("full2_count", 32'(bus.count), 32'd16);
        bus.in_data   = 8'h55;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("pushpop_count", 32'(bus.count), 32'd16);
        check("pushpop_ovf", 32'(bus.overflow), 32'd0);
        tick();
        bus.out_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("drain2_%0d", i), 32'(bus.out_data), 32'(8'h20 + i));
            tick();
        end
        check("drain2_last", 32'(bus.out_data), 32'h55);
        tick();
        bus.out_ready = 1'b0;
        check("drain2_empty", 32'(bus.out_valid), 32'd0);

        // Wrap-around stream with random consumer stalls
        tx_next   = 8'h10;
        rx_next   = 8'h10;
        cyc       = 0;
        max_count = 0;
        while (rx_next < 8'h38 && cyc < 2000) begin
            if (bus.in_valid) begin
                bus.in_valid = 1'b0;
            end else if (tx_next < 8'h38 && int'(bus.count) < DEPTH - 1) begin
                bus.in_data  = 8'(tx_next);
                bus.in_valid = 1'b1;
                tx_next++;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("stream_%0h", rx_next), 32'(bus.out_data), 32'(rx_next));
                rx_next++;
            end
            tick();
            if (int'(bus.count) > max_count) max_count = int'(bus.count);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("stream_done", 32'(rx_next), 32'h38);
        check("stream_max_count_ok", 32'(max_count <= DEPTH), 32'd1);
        check("stream_ovf", 32'(bus.overflow), 32'd0);
        tick();
        check("stream_empty", 32'(bus.count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It converts the receiver's level-style valid (held high until the next start bit) into exactly one push per received byte, and stores bytes in a circular FIFO. Bytes are presented to the consumer through a show-ahead valid/ready interface. Overflow, meaning a byte arriving while the FIFO is full, is dropped and latched in a sticky flag.

Parameters:
DEPTH, 16, number of byte entries; power of two, >= 2
WIDTH, 8, data width in bits

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low; one clock domain (clk)
in_data  input  WIDTH  received byte from UART receiver; stable while in_valid high
in_valid  input  1  receiver data-valid level; each 0->1 transition marks one new byte
out_data  output  WIDTH  byte at FIFO head; meaningful only when out_valid=1
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head byte when out_valid & out_ready
count  output  $clog2(DEPTH)+1  number of stored bytes, 0..DEPTH
overflow  output  1  sticky: a byte was dropped because the FIFO was full
overflow_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst_n=0, async): rd_ptr=wr_ptr=0, count=0, out_valid=0, overflow=0, valid-history register in_valid_q=1. Memory contents are not reset. out_data is don't-care while out_valid=0.
- Resetting in_valid_q to 1 ensures a valid level held high through reset is not captured. Only a fresh 0->1 transition after reset pushes.
- Edge detect: push_req = in_valid & ~in_valid_q. in_valid_q <= in_valid every cycle.
- pop = out_valid & out_ready.
- Push accepted when push_req & (count<DEPTH | pop). On accept: mem[wr_ptr] <= in_data, wr_ptr <= wr_ptr+1 mod DEPTH.
- Push rejected when push_req & count==DEPTH & ~pop. Data is dropped, pointers and count are unchanged, overflow <= 1.
- Pop: rd_ptr <= rd_ptr+1 mod DEPTH.
- count update: +1 on accepted push only, -1 on pop only, unchanged on both or neither.
- Pop when empty is impossible because out_valid=0. out_ready while empty has no effect.
- Show-ahead read: out_data = mem[rd_ptr] combinationally. out_valid = (count!=0).
- Latency: if in_valid first samples high at edge k, the byte is written at edge k. out_valid and count reflect it after edge k, i.e. 1 cycle.
- Simultaneous push and pop:
  - When empty: push only; pop cannot occur.
  - When full: both proceed, count stays DEPTH, no overflow.
- overflow: set on a rejected push; cleared by overflow_clr. If overflow_clr and a rejected push occur in the same cycle, overflow remains 1 (set wins).
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and roll over naturally. Full/empty are determined from count, not pointer comparison.
- Reset mid-operation: all stored bytes are discarded immediately. The first push after release requires a new in_valid rising edge.
- in_valid held high for any number of cycles produces exactly one push. Back-to-back bytes require in_valid to drop for at least 1 cycle; the UART receiver guarantees this.

Test Plan:
- Reset: assert rst_n=0 mid-traffic with count=5 -> count=0, out_valid=0, overflow=0 asynchronously. Hold in_valid=1 through release -> no push, count stays 0.
- Single byte: in_data=0xA5, in_valid 0->1 held 30 cycles, out_ready=0 -> count=1 one cycle after first high sample, out_data=0xA5. Pulse out_ready 1 cycle -> count=0, out_valid=0.
- Fill/overflow: with out_ready=0, push 0x00..0x0F (DEPTH=16) -> count=16. Push 0xFF -> dropped, overflow=1, count=16. Drain -> 0x00..0x0F in order, then out_valid=0.
- Full with simultaneous pop: count=16, out_ready=1 in the same cycle as the push edge of 0x55 -> count stays 16, overflow stays 0, 0x55 is the last byte drained.
- Overflow clear: overflow=1, overflow_clr=1 coincident with a rejected push -> overflow=1. overflow_clr alone next cycle -> overflow=0.
- Wrap-around: stream 40 bytes 0x10..0x37 with out_ready toggling pseudo-randomly -> all 40 bytes received in order, no overflow, count never exceeds 16.
